// File: rtl/wave_meas.sv
// Purpose: measures period, high-time, min, max and peak-to-peak of an unsigned 8-bit waveform using rising mid-level crossings with hysteresis.
// Latency: a crossing sample presented with data_en in cycle N gives a meas_valid strobe in cycle N+2.
// Backpressure: none. The block accepts one sample per cycle when data_en is high, and meas_* is a strobe with no ready.
//
// Ports:
//   sys_clk, sys_rst      : clock and asynchronous active-high reset
//   data_in, data_en      : waveform sample and its qualifier
//   meas_period/high      : cycles between the last two rising events, and the cycles spent HIGH within that span
//   meas_max/min/pp       : sample extremes within that span, and their difference
//   meas_valid            : one-cycle strobe; all meas_* outputs change together on this strobe
//   no_signal             : high until a full period is measured, and again after a timeout
module wave_meas #(
    parameter int MID         = 128,
    parameter int HYST        = 8,
    parameter int PERIOD_W    = 32,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [7:0]          data_in,
    input  logic                data_en,
    output logic [PERIOD_W-1:0] meas_period,
    output logic [PERIOD_W-1:0] meas_high,
    output logic [7:0]          meas_max,
    output logic [7:0]          meas_min,
    output logic [7:0]          meas_pp,
    output logic                meas_valid,
    output logic                no_signal
);

    localparam logic [7:0]          UP_TH   = 8'(MID + HYST);
    localparam logic [7:0]          LO_TH   = 8'(MID - HYST);
    localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT_CYC - 1);
    localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

    typedef enum logic {ST_IDLE, ST_MEAS} state_t;
    typedef enum logic {CMP_LOW, CMP_HIGH} cmp_t;

    // input stage
    logic [7:0]          s_data_q;
    logic                s_en_q;

    state_t              state_q, state_d;
    cmp_t                cmp_q, cmp_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] hi_q, hi_d;
    logic [7:0]          max_q, max_d;
    logic [7:0]          min_q, min_d;

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] high_q, high_d;
    logic [7:0]          omax_q, omax_d;
    logic [7:0]          omin_q, omin_d;
    logic [7:0]          pp_q, pp_d;
    logic                valid_q, valid_d;
    logic                nosig_q, nosig_d;

    logic                rise;
    logic                timeout;
    logic [7:0]          trk_max;
    logic [7:0]          trk_min;

    // Hysteresis comparator. A rising event occurs only on the LOW->HIGH transition.
    always_comb begin
        cmp_d = cmp_q;
        rise  = 1'b0;
        if (s_en_q) begin
            if (cmp_q == CMP_LOW && s_data_q >= UP_TH) begin
                cmp_d = CMP_HIGH;
                rise  = 1'b1;
            end else if (cmp_q == CMP_HIGH && s_data_q <= LO_TH) begin
                cmp_d = CMP_LOW;
            end
        end
    end

    // The tracker values include the current sample, so a captured result contains the event sample.
    assign trk_max = (s_en_q && s_data_q > max_q) ? s_data_q : max_q;
    assign trk_min = (s_en_q && s_data_q < min_q) ? s_data_q : min_q;
    assign timeout = (state_q == ST_MEAS) && (per_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        per_d    = per_q + ONE;
        // cmp_d is the comparator state for this cycle, so the event cycle counts as HIGH.
        hi_d     = hi_q + ((cmp_d == CMP_HIGH) ? ONE : '0);
        max_d    = trk_max;
        min_d    = trk_min;
        period_d = period_q;
        high_d   = high_q;
        omax_d   = omax_q;
        omin_d   = omin_q;
        pp_d     = pp_q;
        valid_d  = 1'b0;
        nosig_d  = nosig_q;

        if (rise) begin
            // A new period starts at the event cycle. The high count starts at 1 because that cycle is HIGH.
            per_d = '0;
            hi_d  = (cmp_d == CMP_HIGH) ? ONE : '0;
            max_d = s_data_q;
            min_d = s_data_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_MEAS;
                end else begin
                    // Hold the counters at zero while idle so they never wrap.
                    per_d = '0;
                    hi_d  = '0;
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    // If an event and a timeout occur in the same cycle, the event takes priority.
                    period_d = per_q + ONE;
                    high_d   = hi_q;
                    omax_d   = trk_max;
                    omin_d   = trk_min;
                    pp_d     = trk_max - trk_min;
                    valid_d  = 1'b1;
                    nosig_d  = 1'b0;
                end else if (timeout) begin
                    nosig_d = 1'b1;
                    state_d = ST_IDLE;
                    per_d   = '0;
                    hi_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s_data_q <= '0;
            s_en_q   <= 1'b0;
            state_q  <= ST_IDLE;
            cmp_q    <= CMP_LOW;
            per_q    <= '0;
            hi_q     <= '0;
            max_q    <= 8'd0;
            min_q    <= 8'd255;
            period_q <= '0;
            high_q   <= '0;
            omax_q   <= '0;
            omin_q   <= '0;
            pp_q     <= '0;
            valid_q  <= 1'b0;
            nosig_q  <= 1'b1;
        end else begin
            s_data_q <= data_in;
            s_en_q   <= data_en;
            state_q  <= state_d;
            cmp_q    <= cmp_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            max_q    <= max_d;
            min_q    <= min_d;
            period_q <= period_d;
            high_q   <= high_d;
            omax_q   <= omax_d;
            omin_q   <= omin_d;
            pp_q     <= pp_d;
            valid_q  <= valid_d;
            nosig_q  <= nosig_d;
        end
    end

    assign meas_period = period_q;
    assign meas_high   = high_q;
    assign meas_max    = omax_q;
    assign meas_min    = omin_q;
    assign meas_pp     = pp_q;
    assign meas_valid  = valid_q;
    assign no_signal   = nosig_q;

endmodule

// File: doc/wave_meas.md
Name: wave_meas

Overview:
- Measurement receiver for the 8-bit waveform stream produced by the DDS generator.
- Consumes unsigned samples and detects rising mid-level crossings with hysteresis.
- Per waveform period, reports period length, high-time, min, max and peak-to-peak.
- Sits downstream of the DDS output; used for on-chip self-check and readback of generated frequency and amplitude.

Parameters:
MID, 128, mid-level threshold (unsigned 8-bit)
HYST, 8, hysteresis half-width; upper threshold = MID+HYST, lower = MID-HYST (must satisfy HYST <= MID and MID+HYST <= 255)
PERIOD_W, 32, width of period/high-time counters
TIMEOUT_CYC, 50000000, cycles without a rising event before no-signal is declared (must be < 2^PERIOD_W)

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst  input  1  asynchronous reset, active-high
data_in  input  8  waveform sample, unsigned
data_en  input  1  sample valid; data_in is ignored when low
meas_period  output  PERIOD_W  sys_clk cycles between the last two rising events
meas_high  output  PERIOD_W  cycles spent in HIGH comparator state within that period
meas_max  output  8  maximum sample within that period
meas_min  output  8  minimum sample within that period
meas_pp  output  8  meas_max - meas_min
meas_valid  output  1  one-cycle strobe; all meas_* outputs update in the same cycle
no_signal  output  1  high when no valid period is currently established

Behaviour:
- Reset (async, any time, including mid-measurement):
  - All meas_* outputs = 0, meas_valid = 0, no_signal = 1.
  - FSM = IDLE, comparator = LOW, counters = 0.
  - Min/max trackers = 255/0.
- Input stage: data_in/data_en are registered once (s_data, s_en). All logic below acts on s_data only when s_en = 1.
- Hysteresis comparator (state LOW/HIGH):
  - LOW -> HIGH when s_data >= MID+HYST.
  - HIGH -> LOW when s_data <= MID-HYST.
  - Otherwise the state holds.
  - A rising event is the LOW->HIGH transition cycle. Samples between the thresholds never generate events.
- Period counter:
  - Cleared to 0 on every rising event; increments every sys_clk cycle, regardless of s_en.
  - At a rising event, captured period = counter + 1, i.e. exactly the cycle distance between the two events.
- High counter: cleared on rising event; increments every cycle while the comparator is HIGH (the event cycle counts as HIGH).
- Min/max trackers:
  - Updated with every valid sample.
  - On a rising event, captured values include the event sample; the trackers then restart from the event sample.
- FSM:
  - IDLE: waits for a rising event. On an event: clear counters and trackers, go to MEAS. No meas_valid is produced.
  - MEAS:
    - On a rising event: register outputs, pulse meas_valid, clear no_signal, stay in MEAS.
    - If the period counter reaches TIMEOUT_CYC-1 with no event: set no_signal = 1, go to IDLE. meas_* hold their last values and no meas_valid is produced.
- Latency: if the threshold-crossing sample is presented on data_in with data_en in cycle N, meas_valid is high in cycle N+2, for exactly 1 cycle.
- Simultaneous rising event and timeout in the same cycle: the event wins (measurement reported, timer cleared).
- meas_pp is registered together with meas_max/meas_min. It is never negative, since max >= min by construction.
- No counter overflow is possible: timeout precedes wrap.

Test Plan:
- Full-scale square, data_en=1, 50 cycles 255 / 50 cycles 0 -> first meas_valid only at 2nd rising edge; meas_period=100, meas_high=50, meas_max=255, meas_min=0, meas_pp=255; no_signal falls with that strobe; strobes repeat every 100 cycles.
- Hysteresis rejection: TIMEOUT_CYC=1000, data alternating 130/126 after one valid period -> no further meas_valid; no_signal=1 exactly 1000 cycles after last event; meas_* hold prior values.
- Chatter at threshold: sequence 100,137,134,137,200,...,100 repeated with period 40 cycles -> one event per period, meas_period=40, no extra strobes.
- data_en gating: data_en high every 4th cycle, square of 10 samples at 200 / 10 samples at 50 -> meas_period=80, meas_high=40, meas_max=200, meas_min=50, meas_pp=150.
- Latency check: single LOW->HIGH crossing sample at cycle N (in MEAS) -> meas_valid asserted in cycle N+2 only.
- Reset mid-period: assert sys_rst while in MEAS, release -> outputs 0, no_signal=1 immediately (async); the first following rising edge produces no strobe, the second produces a correct measurement.
